pipe_skid_ff: RTL and testbench
===============================

# pipe_skid_ff

Parametrised elastic pipeline register: the next generation of the stage flip-flops between IF/ID/EX/MEM/WB. It replaces plain enable/flush registers with a valid/ready handshake and a one-entry skid buffer, so that upstream stall timing is no longer combinationally coupled to downstream stalls. Flush empties the stage and presents the NOP encoding. It sits between any two pipeline stages, starting with instruction fetch → decode.

## Interface
Parameters:
- WIDTH, 32: payload width in bits.
- NOP_VALUE, 32'h0000_0020 (add $0,$0,$0, zero-extended or truncated to WIDTH): value presented on out_data while the stage is empty.

Ports:
- ctrl_bus.clk  in  1  clock, via the ctrl_bus_if.central modport. All state changes on posedge.
- ctrl_bus.reset  in  1  synchronous, active-high reset, via the same modport.
- flush  in  1  synchronous stage flush.
- in_valid  in  1  upstream has a payload.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  stage accepts a payload this cycle. Registered.
- out_valid  out  1  out_data holds a real payload. Registered.
- out_data  out  WIDTH  payload, or NOP_VALUE when empty. Registered.
- out_ready  in  1  downstream consumes a payload this cycle.

## Operation
- Upstream transfer: in_valid && in_ready. Downstream transfer: out_valid && out_ready.
- Storage: a main register drives out_data. A skid register captures the one payload accepted while downstream is stalled.
- State EMPTY: out_valid=0, in_ready=1, out_data=NOP_VALUE.
  - in_valid → FULL, main<=in_data.
- State FULL: out_valid=1, in_ready=1.
  - out_ready && !in_valid → EMPTY, main<=NOP_VALUE.
  - out_ready && in_valid → FULL, main<=in_data.
  - !out_ready && in_valid → SKID, skid<=in_data.
  - Otherwise hold.
- State SKID: out_valid=1, in_ready=0. in_valid is ignored.
  - out_ready → FULL, main<=skid.
  - Otherwise hold.
- Priority: reset, then flush, then handshake.
- Flush: next state EMPTY, main<=NOP_VALUE, skid discarded. An in_valid in the same cycle is dropped. A downstream transfer in the same cycle still counts as consumed.
- Reset values: state EMPTY, out_valid=0, in_ready=1, out_data=NOP_VALUE, skid=NOP_VALUE.
- Ordering is strict FIFO. No payload is lost or duplicated except through flush.

## Timing
- Latency: 1 cycle from an accepted in_data to out_data/out_valid.
- Throughput: 1 payload per cycle while out_ready=1.
- in_ready falls the cycle after a skid capture and rises the cycle after the SKID drain. in_ready never depends combinationally on out_ready.
- Flush or reset asserted in cycle n gives out_valid=0 and out_data=NOP_VALUE in cycle n+1.
- Flush held for several cycles keeps the stage EMPTY.
- Maximum occupancy is 2. in_valid while in SKID is a no-op by handshake definition.

## Configuration
- PIPE_SKID_BUBBLE_COUNT_EN defined:
  - Adds output bubble_count (out, 32): counts cycles with out_ready=1 && out_valid=0.
  - Saturates at 32'hFFFF_FFFF. Cleared by reset, not by flush.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

## Structure
- pipe_pkg holds:
  - enum skid_state_t {EMPTY, FULL, SKID} (2 bits);
  - localparam NOP_INSN = 32'h0000_0020, used as the NOP_VALUE default.
- One sub-module, sat_counter #(WIDTH): synchronous clear, increment enable, saturation. Used for bubble_count.

## Test plan
- Reset: assert reset 2 cycles → out_valid=0, in_ready=1, out_data=32'h20. With the macro, bubble_count=0.
- Streaming: out_ready=1; feed 1,2,3 on consecutive cycles → out_data=1,2,3 on consecutive cycles, in_ready always 1.
- Skid: out_ready=0, feed A then B → out=A, in_ready=0 next cycle. Raise out_ready → A, B in order, in_ready returns 1 after B is moved to main.
- Flush in SKID: state SKID with A/B, pulse flush while in_valid=1 with C → next cycle out_valid=0, out_data=32'h20. A, B and C never appear at the output.
- Reset mid-stream: reset asserted in FULL while out_ready=0 → EMPTY next cycle, identical to the power-on values.
- Bubble counter (macro defined): out_ready=1 with no input for 5 cycles → bubble_count=5. Preload 32'hFFFF_FFFE and idle 3 cycles → bubble_count=32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the elastic pipeline stage.
//   skid_state_t : occupancy state of pipe_skid_ff (EMPTY / FULL / SKID)
//   NOP_INSN     : add $0,$0,$0, presented while a stage holds no payload
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0020;

endpackage

// File: rtl/ctrl_bus_if.sv
// ctrl_bus_if: clock and synchronous reset distribution for pipeline stages.
//   clk   : stage clock, all state changes on posedge
//   reset : synchronous, active-high reset
//   modport central : consumer view (both signals are inputs)
interface ctrl_bus_if;
    logic clk;
    logic reset;

    modport central (
        input clk,
        input reset
    );
endinterface

// File: rtl/pipe_skid_ff_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
//   clk   : clock
//   clear : synchronous clear, wins over inc
//   inc   : count up by one this cycle
//   count : current value
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_ff.sv
// pipe_skid_ff: elastic pipeline register with valid/ready handshake and a
// one-entry skid buffer. in_ready is a flop, so upstream stall timing never
// depends combinationally on out_ready. Flush empties the stage and shows NOP.
//
// Optional feature (macro PIPE_SKID_BUBBLE_COUNT_EN): adds bubble_count, a
// saturating count of cycles with out_ready=1 && out_valid=0, cleared by reset.
//
// Ports:
//   ctrl_bus     : clk / synchronous active-high reset (central modport)
//   flush        : synchronous stage flush
//   in_valid     : upstream has a payload
//   in_data      : upstream payload
//   in_ready     : stage accepts a payload this cycle (registered)
//   out_valid    : out_data holds a real payload (registered)
//   out_data     : payload, or NOP_VALUE when empty (registered)
//   out_ready    : downstream consumes a payload this cycle
//   bubble_count : (macro only) downstream-idle cycle counter
//
// state | meaning
// EMPTY | no payload; out_data = NOP, accepting
// FULL  | one payload in main; accepting
// SKID  | main and skid both hold payloads; not accepting
module pipe_skid_ff
    import pipe_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] NOP_VALUE = NOP_INSN
) (
    ctrl_bus_if.central      ctrl_bus,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_SKID_BUBBLE_COUNT_EN
    ,
    output logic [31:0]      bubble_count
`endif
);

    // Zero-extends or truncates the 32-bit NOP encoding to the payload width.
    localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_VALUE);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             out_valid_q;

    always_ff @(posedge ctrl_bus.clk) begin
        if (ctrl_bus.reset) begin
            state_q     <= EMPTY;
            main_q      <= NOP_W;
            skid_q      <= NOP_W;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            // Handshake flags are decoded from the next state so they are
            // plain flop outputs.
            in_ready_q  <= (state_d != SKID);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = NOP_W;
            skid_d  = NOP_W;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            main_d = in_data;
                        end else begin
                            state_d = EMPTY;
                            main_d  = NOP_W;
                        end
                    end else if (in_valid) begin
                        state_d = SKID;
                        skid_d  = in_data;
                    end
                end
                SKID: begin
                    // in_ready is low here, so in_valid cannot transfer.
                    if (out_ready) begin
                        state_d = FULL;
                        main_d  = skid_q;
                        skid_d  = NOP_W;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_W;
                    skid_d  = NOP_W;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef PIPE_SKID_BUBBLE_COUNT_EN
    sat_counter #(
        .WIDTH (32)
    ) u_bubble_cnt (
        .clk   (ctrl_bus.clk),
        .clear (ctrl_bus.reset),
        .inc   (out_ready && !out_valid_q),
        .count (bubble_count)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_ff.sv
// tb_pipe_skid_ff: directed vectors with a scoreboard queue. The stimulus
// pushes each payload it expects the stage to accept; the monitor pops on
// every downstream transfer and compares.
module tb_pipe_skid_ff;
    import pipe_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] NOP = 32'h0000_0020;

    ctrl_bus_if cb ();

    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
`ifdef PIPE_SKID_BUBBLE_COUNT_EN
    logic [31:0]  bubble_count;
`endif

    logic         sc_clear;
    logic         sc_inc;
    logic [1:0]   sc_count;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    bit mon_en   = 0;

    logic [W-1:0] sb[$];

    typedef struct {
        logic         rst;
        logic         fl;
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         exp_ir;
    } vec_t;

    vec_t vecs[$];

    pipe_skid_ff #(
        .WIDTH     (W),
        .NOP_VALUE (NOP_INSN)
    ) dut (
        .ctrl_bus     (cb.central),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready)
`ifdef PIPE_SKID_BUBBLE_COUNT_EN
        ,
        .bubble_count (bubble_count)
`endif
    );

    sat_counter #(
        .WIDTH (2)
    ) u_sc (
        .clk   (cb.clk),
        .clear (sc_clear),
        .inc   (sc_inc),
        .count (sc_count)
    );

    initial cb.clk = 1'b0;
    always #5 cb.clk = ~cb.clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic add(input logic rst, input logic fl, input logic iv,
                       input logic [W-1:0] d, input logic ordy, input logic exp_ir);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy; v.exp_ir = exp_ir;
        vecs.push_back(v);
    endtask

    // Monitor: sample mid-cycle, pop on each downstream transfer.
    always @(negedge cb.clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output got=%h exp=none", out_data);
                end else begin
                    check("out_data", out_data, sb.pop_front());
                    pops++;
                end
            end else if (!out_valid) begin
                check("empty_nop", out_data, NOP);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //   rst fl iv  data          ordy exp_in_ready
        // streaming 1,2,3
        add(0, 0, 1, 32'h1,        1, 1);
        add(0, 0, 1, 32'h2,        1, 1);
        add(0, 0, 1, 32'h3,        1, 1);
        add(0, 0, 0, 32'h0,        1, 1);
        add(0, 0, 0, 32'h0,        1, 1);
        // skid: A then B with downstream stalled, extra beat ignored
        add(0, 0, 1, 32'hAAAA_0001, 0, 1);
        add(0, 0, 1, 32'hBBBB_0002, 0, 1);
        add(0, 0, 1, 32'hDEAD_BEEF, 0, 0);
        add(0, 0, 0, 32'h0,        1, 0);
        add(0, 0, 0, 32'h0,        1, 1);
        // flush in SKID with C offered
        add(0, 0, 1, 32'hA2A2_0003, 0, 1);
        add(0, 0, 1, 32'hB2B2_0004, 0, 1);
        add(0, 1, 1, 32'hCCCC_0005, 0, 0);
        add(0, 0, 0, 32'h0,        1, 1);
        // flush with a simultaneous downstream transfer, then held flush
        add(0, 0, 1, 32'hEEEE_0006, 0, 1);
        add(0, 1, 1, 32'hFFFF_0007, 1, 1);
        add(0, 1, 0, 32'h0,        1, 1);
        add(0, 0, 1, 32'h6666_0008, 0, 1);
        // reset while FULL and stalled
        add(1, 0, 0, 32'h0,        0, 1);
        add(0, 0, 0, 32'h0,        1, 1);

        cb.reset  = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        sc_clear  = 1'b0;
        sc_inc    = 1'b0;
        repeat (2) @(posedge cb.clk);
        #1;
        cb.reset = 1'b0;
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_in_ready", W'(in_ready), W'(1'b1));
        check("rst_out_data", out_data, NOP);
`ifdef PIPE_SKID_BUBBLE_COUNT_EN
        check("rst_bubble", bubble_count, 32'd0);
`endif
        mon_en = 1;

        foreach (vecs[i]) begin
            cb.reset  = vecs[i].rst;
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            @(negedge cb.clk);
            check($sformatf("in_ready[%0d]", i), W'(in_ready), W'(vecs[i].exp_ir));
            if (vecs[i].iv && vecs[i].exp_ir && !vecs[i].fl && !vecs[i].rst)
                sb.push_back(vecs[i].d);
            @(posedge cb.clk);
            #1;
            if (vecs[i].fl || vecs[i].rst) sb.delete();
            if (vecs[i].rst) begin
                cb.reset = 1'b0;
                check("midrst_out_valid", W'(out_valid), W'(1'b0));
                check("midrst_in_ready", W'(in_ready), W'(1'b1));
                check("midrst_out_data", out_data, NOP);
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        // Delivered: 1,2,3,A,B,E
        check("pop_count", W'(pops), W'(6));

`ifdef PIPE_SKID_BUBBLE_COUNT_EN
        cb.reset  = 1'b1;
        out_ready = 1'b0;
        @(posedge cb.clk);
        #1;
        cb.reset  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge cb.clk);
        #1;
        check("bubble_5", bubble_count, 32'd5);
`endif

        sc_clear = 1'b1;
        @(posedge cb.clk);
        #1;
        sc_clear = 1'b0;
        check("sat_clear", W'(sc_count), W'(0));
        sc_inc = 1'b1;
        repeat (2) @(posedge cb.clk);
        #1;
        check("sat_two", W'(sc_count), W'(2));
        repeat (3) @(posedge cb.clk);
        #1;
        check("sat_hold", W'(sc_count), W'(3));
        sc_inc = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
